// File: rtl/ext_input_conditioner_pkg.sv
// Shared definitions for the external input conditioner.
//   cnt_width()       : debounce counter width for a given debounce depth
//   MinSyncStages     : smallest legal synchronizer depth
//   MinDebounceCycles : smallest legal debounce depth
package ext_cond_pkg;

  localparam int unsigned MinSyncStages     = 2;
  localparam int unsigned MinDebounceCycles = 1;

  // Counter must hold 0 .. d-1; $clog2(d+1) keeps it at least 1 bit wide for d == 1.
  function automatic int unsigned cnt_width(int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/ext_input_conditioner_if.sv
// Bundle of the conditioner's per-channel data signals.
//   data_in  : raw asynchronous inputs (driven by the pad side)
//   data_out : synchronized, debounced levels
//   rise     : one-cycle pulse when a data_out bit goes 0->1
//   fall     : one-cycle pulse when a data_out bit goes 1->0
// master modport is the pad/core side, slave modport is the conditioner.
interface ext_input_conditioner_if #(
  parameter int unsigned NUM_CH = 1
);

  logic [NUM_CH-1:0] data_in;
  logic [NUM_CH-1:0] data_out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;

  modport master (
    output data_in,
    input  data_out,
    input  rise,
    input  fall
  );

  modport slave (
    input  data_in,
    output data_out,
    output rise,
    output fall
  );

endinterface

// File: rtl/ext_input_conditioner_channel.sv
// One conditioner channel: synchronizer chain followed by a debounce filter.
// Optional macro EXT_COND_EDGE_EN adds registered rise/fall pulses; otherwise they are tied to 0.
// Ports:
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   data_in  : raw asynchronous input bit
//   data_out : synchronized, debounced level
//   rise     : one-cycle pulse coincident with data_out going 0->1
//   fall     : one-cycle pulse coincident with data_out going 1->0
module ext_cond_channel
  import ext_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic data_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   data_q, data_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   accept;

  // Plain flop chain, nothing between stages; sync_q[0] is the first stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], data_in};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // New level is accepted on the D-th consecutive mismatching cycle.
  assign accept = (sync_s != data_q) && (cnt_q == CntMax);

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (sync_s == data_q) begin
      // Any return to agreement throws away partial credit.
      cnt_d = '0;
    end else if (accept) begin
      data_d = sync_s;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= RESET_VALUE;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_out = data_q;

`ifdef EXT_COND_EDGE_EN
  logic rise_q, fall_q;

  // Registered alongside data_q so the pulse lines up with the new data_out value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= accept & sync_s;
      fall_q <= accept & ~sync_s;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/ext_input_conditioner.sv
// Multi-channel conditioner for asynchronous external inputs. Each channel is synchronized
// through SYNC_STAGES flops and then debounced over DEBOUNCE_CYCLES cycles.
// Optional macro EXT_COND_EDGE_EN enables registered rise/fall pulses; without it the
// rise/fall signals are driven to 0.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : ext_input_conditioner_if.slave (data_in, data_out, rise, fall; NUM_CH bits each)
module ext_input_conditioner
  import ext_cond_pkg::*;
#(
  parameter int unsigned       NUM_CH          = 1,
  parameter int unsigned       SYNC_STAGES     = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = 1,
  parameter logic [NUM_CH-1:0] RESET_VALUE     = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  ext_input_conditioner_if.slave   bus
);

  if (NUM_CH < 1) begin : gen_bad_num_ch
    $error("NUM_CH must be >= 1");
  end
  if (SYNC_STAGES < MinSyncStages) begin : gen_bad_sync_stages
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < MinDebounceCycles) begin : gen_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  logic [NUM_CH-1:0] data_out_w;
  logic [NUM_CH-1:0] rise_w;
  logic [NUM_CH-1:0] fall_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    ext_cond_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .data_in  (bus.data_in[i]),
      .data_out (data_out_w[i]),
      .rise     (rise_w[i]),
      .fall     (fall_w[i])
    );
  end

  assign bus.data_out = data_out_w;
  assign bus.rise     = rise_w;
  assign bus.fall     = fall_w;

endmodule

// File: tb/tb_ext_input_conditioner.sv
// Directed bench for ext_input_conditioner with three configurations:
//   dut_a: NUM_CH=4, SYNC_STAGES=3, DEBOUNCE_CYCLES=4, RESET_VALUE=4'b1010
//   dut_b: NUM_CH=1, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VALUE=1'b0
//   dut_c: NUM_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=1, RESET_VALUE=2'b01
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ext_input_conditioner;

`ifdef EXT_COND_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ext_input_conditioner_if #(.NUM_CH(4)) bus_a ();
  ext_input_conditioner_if #(.NUM_CH(1)) bus_b ();
  ext_input_conditioner_if #(.NUM_CH(2)) bus_c ();

  ext_input_conditioner #(
    .NUM_CH          (4),
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (4'b1010)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  ext_input_conditioner #(
    .NUM_CH          (1),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  ext_input_conditioner #(
    .NUM_CH          (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (1),
    .RESET_VALUE     (2'b01)
  ) dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_c.slave)
  );

  task automatic test_reset();
    reset = 1'b1;
    bus_a.data_in = 4'b1010;
    bus_b.data_in = 1'b0;
    bus_c.data_in = 2'b01;
    #2 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.data_out !== 4'b1010) begin
        n_fail++;
        $display("FAIL reset_a_data_out i=%0d got %b expected 1010", i, bus_a.data_out);
      end
      n_checks++;
      if ({bus_a.rise, bus_a.fall} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_a_edges i=%0d got rise=%b fall=%b expected 0", i, bus_a.rise,
                 bus_a.fall);
      end
      n_checks++;
      if ({bus_b.data_out, bus_c.data_out} !== 3'b001) begin
        n_fail++;
        $display("FAIL reset_bc_data_out i=%0d got b=%b c=%b expected b=0 c=01", i,
                 bus_b.data_out, bus_c.data_out);
      end
      bus_a.data_in = 4'(i * 5 + 3);
      bus_b.data_in = ~bus_b.data_in;
      bus_c.data_in = 2'(i);
    end
    @(negedge clk);
    bus_a.data_in = 4'b1010;
    bus_b.data_in = 1'b0;
    bus_c.data_in = 2'b01;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (bus_a.data_out !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_release_a got %b expected 1010", bus_a.data_out);
    end
  endtask

  task automatic test_latency();
    logic [3:0] exp_out;
    logic       exp_edge;
    bus_a.data_in[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_out  = (e >= 7) ? 4'b1011 : 4'b1010;
      exp_edge = EdgeEn && (e == 7);
      n_checks++;
      if (bus_a.data_out !== exp_out) begin
        n_fail++;
        $display("FAIL latency_rise_out edge=%0d got %b expected %b", e, bus_a.data_out, exp_out);
      end
      n_checks++;
      if ({bus_a.rise, bus_a.fall} !== {3'b000, exp_edge, 4'b0000}) begin
        n_fail++;
        $display("FAIL latency_rise_pulse edge=%0d got rise=%b fall=%b expected rise=%b", e,
                 bus_a.rise, bus_a.fall, {3'b000, exp_edge});
      end
    end
    bus_a.data_in[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_out  = (e >= 7) ? 4'b1010 : 4'b1011;
      exp_edge = EdgeEn && (e == 7);
      n_checks++;
      if (bus_a.data_out !== exp_out) begin
        n_fail++;
        $display("FAIL latency_fall_out edge=%0d got %b expected %b", e, bus_a.data_out, exp_out);
      end
      n_checks++;
      if ({bus_a.rise, bus_a.fall} !== {4'b0000, 3'b000, exp_edge}) begin
        n_fail++;
        $display("FAIL latency_fall_pulse edge=%0d got rise=%b fall=%b expected fall=%b", e,
                 bus_a.rise, bus_a.fall, {3'b000, exp_edge});
      end
    end
  endtask

  task automatic test_glitch();
    bus_a.data_in[0] = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(negedge clk);
      n_checks++;
      if (bus_a.data_out !== 4'b1010) begin
        n_fail++;
        $display("FAIL glitch_out edge=%0d got %b expected 1010", e, bus_a.data_out);
      end
      n_checks++;
      if ({bus_a.rise, bus_a.fall} !== 8'h00) begin
        n_fail++;
        $display("FAIL glitch_pulse edge=%0d got rise=%b fall=%b expected 0", e, bus_a.rise,
                 bus_a.fall);
      end
      if (e == 3) bus_a.data_in[0] = 1'b0;
    end
  endtask

  task automatic test_bounce();
    bit         pat [0:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp_out;
    logic       exp_edge;
    bus_a.data_in[0] = pat[0];
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      // Last run of four 1s starts at the 4th sample (edge 4): 4 + 3 + 4 - 1 = edge 10.
      exp_out  = (e >= 10) ? 4'b1011 : 4'b1010;
      exp_edge = EdgeEn && (e == 10);
      n_checks++;
      if (bus_a.data_out !== exp_out) begin
        n_fail++;
        $display("FAIL bounce_out edge=%0d got %b expected %b", e, bus_a.data_out, exp_out);
      end
      n_checks++;
      if (bus_a.rise[0] !== exp_edge) begin
        n_fail++;
        $display("FAIL bounce_rise edge=%0d got %b expected %b", e, bus_a.rise[0], exp_edge);
      end
      bus_a.data_in[0] = (e < 7) ? pat[e] : 1'b1;
    end
    bus_a.data_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (bus_a.data_out !== 4'b1010) begin
      n_fail++;
      $display("FAIL bounce_restore got %b expected 1010", bus_a.data_out);
    end
  endtask

  task automatic test_independence();
    logic [3:0] exp_out;
    logic [3:0] exp_rise;
    bus_a.data_in = 4'b1101;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_out  = (e >= 7) ? 4'b1111 : 4'b1010;
      exp_rise = (EdgeEn && (e == 7)) ? 4'b0101 : 4'b0000;
      n_checks++;
      if (bus_a.data_out !== exp_out) begin
        n_fail++;
        $display("FAIL indep_out edge=%0d got %b expected %b", e, bus_a.data_out, exp_out);
      end
      n_checks++;
      if ({bus_a.rise, bus_a.fall} !== {exp_rise, 4'b0000}) begin
        n_fail++;
        $display("FAIL indep_pulse edge=%0d got rise=%b fall=%b expected rise=%b fall=0000", e,
                 bus_a.rise, bus_a.fall, exp_rise);
      end
      if (e == 1) bus_a.data_in = 4'b1111;
    end
    bus_a.data_in = 4'b1010;
    repeat (8) @(negedge clk);
    n_checks++;
    if (bus_a.data_out !== 4'b1010) begin
      n_fail++;
      $display("FAIL indep_restore got %b expected 1010", bus_a.data_out);
    end
  endtask

  task automatic test_no_filter();
    logic [1:0] exp_out;
    logic [3:0] exp_edges;
    bus_c.data_in = 2'b10;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      exp_out   = (e >= 3) ? 2'b10 : 2'b01;
      exp_edges = (EdgeEn && (e == 3)) ? 4'b1001 : 4'b0000;
      n_checks++;
      if (bus_c.data_out !== exp_out) begin
        n_fail++;
        $display("FAIL nofilter_out edge=%0d got %b expected %b", e, bus_c.data_out, exp_out);
      end
      n_checks++;
      if ({bus_c.rise, bus_c.fall} !== exp_edges) begin
        n_fail++;
        $display("FAIL nofilter_pulse edge=%0d got rise/fall=%b expected %b", e,
                 {bus_c.rise, bus_c.fall}, exp_edges);
      end
    end
  endtask

  task automatic test_reset_mid_filter();
    logic exp_out;
    logic exp_edge;
    bus_b.data_in = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (bus_b.data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_setup got %b expected 1", bus_b.data_out);
    end
    // s sees 0 after edge 2; edges 3 and 4 leave cnt at 2 of 4.
    bus_b.data_in = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus_b.data_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pending got %b expected 1", bus_b.data_out);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus_b.data_out, bus_b.rise, bus_b.fall} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_async got out/rise/fall=%b expected 000",
               {bus_b.data_out, bus_b.rise, bus_b.fall});
    end
    n_checks++;
    if ({bus_a.data_out, bus_c.data_out} !== 6'b1010_01) begin
      n_fail++;
      $display("FAIL midrst_others got a=%b c=%b expected a=1010 c=01", bus_a.data_out,
               bus_c.data_out);
    end
    @(negedge clk);
    bus_b.data_in = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus_b.data_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_held got %b expected 0", bus_b.data_out);
    end
    reset = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      exp_out  = (e >= 6);
      exp_edge = EdgeEn && (e == 6);
      n_checks++;
      if (bus_b.data_out !== exp_out) begin
        n_fail++;
        $display("FAIL midrst_latency edge=%0d got %b expected %b", e, bus_b.data_out, exp_out);
      end
      n_checks++;
      if ({bus_b.rise, bus_b.fall} !== {exp_edge, 1'b0}) begin
        n_fail++;
        $display("FAIL midrst_pulse edge=%0d got rise=%b fall=%b expected rise=%b", e,
                 bus_b.rise, bus_b.fall, exp_edge);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_bounce();
    test_independence();
    test_no_filter();
    test_reset_mid_filter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
